// File: rtl/lcd1602_bus_timer.sv
// HD44780/LCD1602 bus sequencer: turns one-cycle read/write requests into timed E/RS/RW strobes and data-bus drive.
// Optional 4-bit bus mode with two nibble transfers per request: define LCD1602_NIBBLE_EN.
module lcd1602_bus_timer #(
  parameter int unsigned T_AS_CYC  = 2,
  parameter int unsigned T_PW_CYC  = 12,
  parameter int unsigned T_H_CYC   = 2,
  parameter int unsigned T_GAP_CYC = 20
) (
  input  logic       in_clock,
  input  logic       rst,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       busy,
  output logic       drop,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db_o,
  output logic       lcd_db_oe,
  input  logic [7:0] lcd_db_i
);

  typedef enum logic [2:0] {IDLE, SETUP, E_HIGH, HOLD, GAP} state_t;

  localparam logic [7:0] AS_LD  = 8'(T_AS_CYC - 1);
  localparam logic [7:0] PW_LD  = 8'(T_PW_CYC - 1);
  localparam logic [7:0] H_LD   = 8'(T_H_CYC - 1);
  localparam logic [7:0] GAP_LD = 8'(T_GAP_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cnt_zero;
  logic       accept;
  logic       capture;
  logic       in_xfer;
  logic       rs_q;
  logic       rd_q;
  logic [7:0] data_q;
  logic       drop_q;
  logic       rd_valid_q;
  logic [7:0] rd_data_q;
`ifdef LCD1602_NIBBLE_EN
  logic       phase_q, phase_d;
`endif

  assign cnt_zero = (cnt_q == '0);
  assign capture  = (state_q == E_HIGH) && cnt_zero && rd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 8'd1;
    accept  = 1'b0;
`ifdef LCD1602_NIBBLE_EN
    phase_d = phase_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (req_wr || req_rd) begin
          accept  = 1'b1;
          state_d = SETUP;
          cnt_d   = AS_LD;
`ifdef LCD1602_NIBBLE_EN
          phase_d = 1'b0;
`endif
        end
      end
      SETUP: if (cnt_zero) begin
        state_d = E_HIGH;
        cnt_d   = PW_LD;
      end
      E_HIGH: if (cnt_zero) begin
        state_d = HOLD;
        cnt_d   = H_LD;
      end
      HOLD: if (cnt_zero) begin
        state_d = GAP;
        cnt_d   = GAP_LD;
      end
      GAP: if (cnt_zero) begin
`ifdef LCD1602_NIBBLE_EN
        // first nibble's gap loops straight back into a second SETUP
        if (!phase_q) begin
          state_d = SETUP;
          cnt_d   = AS_LD;
          phase_d = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
`else
        state_d = IDLE;
        cnt_d   = '0;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rs_q       <= 1'b0;
      rd_q       <= 1'b0;
      data_q     <= '0;
      drop_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef LCD1602_NIBBLE_EN
      phase_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef LCD1602_NIBBLE_EN
      phase_q <= phase_d;
`endif
      if (accept) begin
        rs_q <= req_rs;
        rd_q <= ~req_wr;
        if (req_wr) data_q <= req_data;
      end
      drop_q <= ((state_q != IDLE) && (req_wr || req_rd)) ||
                ((state_q == IDLE) && req_wr && req_rd);
`ifdef LCD1602_NIBBLE_EN
      rd_valid_q <= capture && phase_q;
      if (capture) begin
        if (!phase_q) rd_data_q[7:4] <= lcd_db_i[7:4];
        else          rd_data_q[3:0] <= lcd_db_i[7:4];
      end
`else
      rd_valid_q <= capture;
      if (capture) rd_data_q <= lcd_db_i;
`endif
    end
  end

  assign in_xfer   = (state_q == SETUP) || (state_q == E_HIGH) || (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign drop      = drop_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign lcd_e     = (state_q == E_HIGH);
  assign lcd_rs    = rs_q;
  assign lcd_rw    = in_xfer & rd_q;
  assign lcd_db_oe = in_xfer & ~rd_q;
`ifdef LCD1602_NIBBLE_EN
  assign lcd_db_o  = {(phase_q ? data_q[3:0] : data_q[7:4]), 4'h0};
`else
  assign lcd_db_o  = data_q;
`endif

endmodule

// File: tb/tb_lcd1602_bus_timer.sv
// Self-checking bench for lcd1602_bus_timer: directed scenarios plus random traffic against a per-cycle timing model.
module tb_lcd1602_bus_timer;

  localparam int AS    = 2;
  localparam int PW    = 12;
  localparam int H     = 2;
  localparam int GP    = 20;
  localparam int UNIT  = AS + PW + H + GP;
`ifdef LCD1602_NIBBLE_EN
  localparam int NH    = 2;
`else
  localparam int NH    = 1;
`endif
  localparam int TOTAL = UNIT * NH;

  logic       in_clock = 1'b0;
  logic       rst = 1'b1;
  logic       req_wr = 1'b0, req_rd = 1'b0, req_rs = 1'b0;
  logic [7:0] req_data = '0, lcd_db_i = '0;
  logic       busy, drop, rd_valid, lcd_e, lcd_rs, lcd_rw, lcd_db_oe;
  logic [7:0] rd_data, lcd_db_o;

  lcd1602_bus_timer #(.T_AS_CYC(AS), .T_PW_CYC(PW), .T_H_CYC(H), .T_GAP_CYC(GP)) dut (
    .in_clock(in_clock), .rst(rst), .req_wr(req_wr), .req_rd(req_rd), .req_rs(req_rs),
    .req_data(req_data), .busy(busy), .drop(drop), .rd_data(rd_data), .rd_valid(rd_valid),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db_o(lcd_db_o),
    .lcd_db_oe(lcd_db_oe), .lcd_db_i(lcd_db_i)
  );

  always #5 in_clock = ~in_clock;

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position k (1..TOTAL) within the busy window decides every output.
  bit         m_active;
  int         m_k;
  logic       m_rs, m_rd, m_drop, m_rdv;
  logic [7:0] m_data, m_rd_data;

  task automatic model_advance(input logic wr, rd, rs, input logic [7:0] d, dbi, input logic r);
    int u, half;
    if (r) begin
      m_active = 0; m_k = 0; m_rs = 0; m_rd = 0; m_data = '0; m_rd_data = '0;
      m_drop = 0; m_rdv = 0;
    end else begin
      m_drop = (m_active && (wr || rd)) || (!m_active && wr && rd);
      m_rdv  = 0;
      if (m_active) begin
        u    = (m_k - 1) % UNIT + 1;
        half = (m_k - 1) / UNIT;
        if (m_rd && u == AS + PW) begin
          if (NH == 1) begin
            m_rd_data = dbi; m_rdv = 1;
          end else if (half == 0) begin
            m_rd_data[7:4] = dbi[7:4];
          end else begin
            m_rd_data[3:0] = dbi[7:4]; m_rdv = 1;
          end
        end
        m_k++;
        if (m_k > TOTAL) begin m_active = 0; m_k = 0; end
      end else if (wr || rd) begin
        m_active = 1; m_k = 1; m_rs = rs; m_rd = ~wr;
        if (wr) m_data = d;
      end
    end
  endtask

  task automatic compare_outputs();
    int u, half;
    logic ee, inx;
    logic [7:0] edb;
    u    = m_active ? (m_k - 1) % UNIT + 1 : 0;
    half = m_active ? (m_k - 1) / UNIT : 0;
    ee   = m_active && u >= AS + 1 && u <= AS + PW;
    inx  = m_active && u <= AS + PW + H;
    edb  = (NH == 1) ? m_data : {(half != 0 ? m_data[3:0] : m_data[7:4]), 4'h0};
    check("busy", busy, m_active);
    check("lcd_e", lcd_e, ee);
    check("lcd_rs", lcd_rs, m_rs);
    check("lcd_rw", lcd_rw, inx && m_rd);
    check("db_oe", lcd_db_oe, inx && !m_rd);
    if (inx && !m_rd) check("db_o", lcd_db_o, edb);
    check("drop", drop, m_drop);
    check("rd_valid", rd_valid, m_rdv);
    check("rd_data", rd_data, m_rd_data);
  endtask

  // Per-transfer statistics gathered from DUT outputs
  int bl, el, fe, nd, nv, nrw, noe, ne;
  logic prev_e;
  logic [7:0] edbs [2];

  task automatic clear_stats();
    bl = 0; el = 0; fe = 0; nd = 0; nv = 0; nrw = 0; noe = 0; ne = 0; prev_e = 0;
    edbs[0] = '0; edbs[1] = '0;
  endtask

  task automatic step(input logic wr, rd, rs, input logic [7:0] d, dbi, input logic r);
    req_wr = wr; req_rd = rd; req_rs = rs; req_data = d; lcd_db_i = dbi; rst = r;
    model_advance(wr, rd, rs, d, dbi, r);
    @(posedge in_clock);
    #1;
    compare_outputs();
    if (busy === 1'b1) bl++;
    if (lcd_e === 1'b1) begin
      if (el == 0) fe = bl;
      el++;
      if (!prev_e && ne < 2) edbs[ne] = lcd_db_o;
      if (!prev_e) ne++;
    end
    prev_e = (lcd_e === 1'b1);
    if (drop === 1'b1) nd++;
    if (rd_valid === 1'b1) nv++;
    if (lcd_rw === 1'b1) nrw++;
    if (lcd_db_oe === 1'b1) noe++;
  endtask

  task automatic run_until_idle(input bit rd_pattern);
    logic [7:0] dbi;
    for (int i = 0; i < 4 * TOTAL && busy === 1'b1; i++) begin
      if (NH == 1) dbi = 8'h80;
      else dbi = (bl <= UNIT) ? 8'h30 : 8'hC0;
      step(0, 0, 0, 8'h00, rd_pattern ? dbi : 8'h00, 0);
    end
    check("idle_reached", busy, 1'b0);
  endtask

  logic [7:0] wdat;

  initial begin
    clear_stats();
    model_advance(0, 0, 0, 8'h00, 8'h00, 1);

    // Reset values
    step(0, 0, 0, 8'h00, 8'h00, 1);
    step(0, 0, 0, 8'h00, 8'h00, 1);
    check("rst_db_o", lcd_db_o, 8'h00);
    check("rst_busy", busy, 1'b0);
    step(0, 0, 0, 8'h00, 8'h00, 0);

    // Write rs=1
    wdat = (NH == 1) ? 8'h41 : 8'hA5;
    clear_stats();
    step(1, 0, 1, wdat, 8'h00, 0);
    run_until_idle(0);
    check("wr_busy_len", bl, TOTAL);
    check("wr_first_e", fe, AS + 1);
    check("wr_e_len", el, PW * NH);
    check("wr_e_pulses", ne, NH);
    check("wr_db_e0", edbs[0], (NH == 1) ? wdat : {wdat[7:4], 4'h0});
    if (NH == 2) check("wr_db_e1", edbs[1], {wdat[3:0], 4'h0});

    // Read rs=0
    clear_stats();
    step(0, 1, 0, 8'h00, 8'h00, 0);
    run_until_idle(1);
    check("rd_valid_cnt", nv, 1);
    check("rd_data_val", rd_data, (NH == 1) ? 8'h80 : 8'h3C);
    check("rd_rw_cycles", nrw, (AS + PW + H) * NH);
    check("rd_oe_cycles", noe, 0);
    check("rd_busy_len", bl, TOTAL);

    // Request while busy
    clear_stats();
    step(1, 0, 1, 8'h3C, 8'h00, 0);
    for (int i = 0; i < 20 && bl < 10; i++) step(0, 0, 0, 8'h00, 8'h00, 0);
    step(1, 0, 0, 8'hC3, 8'h00, 0);
    run_until_idle(0);
    check("busy_drop_cnt", nd, 1);
    check("busy_len2", bl, TOTAL);

    // Simultaneous write and read
    clear_stats();
    step(1, 1, 1, 8'h5A, 8'hFF, 0);
    run_until_idle(0);
    check("sim_drop_cnt", nd, 1);
    check("sim_rdv_cnt", nv, 0);
    check("sim_rw_cycles", nrw, 0);
    check("sim_busy_len", bl, TOTAL);

    // Reset on the 5th E_HIGH cycle
    clear_stats();
    step(1, 0, 1, 8'h77, 8'h00, 0);
    for (int i = 0; i < 20 && bl < AS + 5; i++) step(0, 0, 0, 8'h00, 8'h00, 0);
    check("pre_rst_e", lcd_e, 1'b1);
    step(0, 0, 0, 8'h00, 8'h00, 1);
    check("abort_e", lcd_e, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_oe", lcd_db_oe, 1'b0);
    check("abort_db_o", lcd_db_o, 8'h00);
    step(0, 0, 0, 8'h00, 8'h00, 0);
    clear_stats();
    step(1, 0, 0, 8'h5A, 8'h00, 0);
    run_until_idle(0);
    check("post_rst_len", bl, TOTAL);
    check("post_rst_e_len", el, PW * NH);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 8) == 0, ($urandom % 8) == 0, $urandom % 2,
           8'($urandom), 8'($urandom), ($urandom % 400) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/lcd1602_bus_timer.md
Name: lcd1602_bus_timer

Overview:
- Cycle-accurate HD44780/LCD1602 bus sequencer. Sits directly downstream of the Z80 I/O port decode: it takes one-cycle read/write requests, already synchronised to in_clock, and produces the lcd_e / lcd_rs / lcd_rw strobes and the data-bus drive.
- Replaces the direct IOWR-derived E pulse. E width and setup/hold become independent of CPU bus timing.
- Exposes busy and read-back data to the port logic.

Parameters:
- T_AS_CYC, 2, cycles RS/RW/DB stable before E rises (range 1..255)
- T_PW_CYC, 12, cycles E held high (range 1..255)
- T_H_CYC, 2, cycles RS/RW/DB held after E falls (range 1..255)
- T_GAP_CYC, 20, idle cycles after hold before the next transfer (range 1..255)

Ports:
- in_clock  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_wr  in  1  one-cycle write request
- req_rd  in  1  one-cycle read request
- req_rs  in  1  register select for the request (0 = instruction/status, 1 = data)
- req_data  in  8  write data, sampled with req_wr
- busy  out  1  transfer in progress; requests are not accepted while high
- drop  out  1  one-cycle pulse: a request arrived while busy, or a read lost to a simultaneous write
- rd_data  out  8  last value read from the LCD
- rd_valid  out  1  one-cycle pulse: rd_data updated
- lcd_e  out  1  LCD enable
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/not-write
- lcd_db_o  out  8  LCD data-bus output value
- lcd_db_oe  out  1  LCD data-bus output enable; the pad tri-states when low
- lcd_db_i  in  8  LCD data-bus input value

Behaviour:
- Clocking and reset: rst is synchronous and active-high, on in_clock.
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db_o=0, lcd_db_oe=0, busy=0, drop=0, rd_valid=0, rd_data=0. FSM goes to IDLE.
- Reset mid-transfer: the transfer aborts. lcd_e is low on the edge after rst is sampled; no partial rd_valid is issued.
- FSM states: IDLE -> SETUP -> E_HIGH -> HOLD -> GAP -> IDLE. One 8-bit down-counter is reloaded on every state entry with (param-1); the state advances when the counter reaches 0.
- Accept (IDLE, req_wr or req_rd):
  - latch req_rs, req_data and direction;
  - busy=1 from the next cycle.
- Simultaneous req_wr and req_rd: the write wins and drop pulses.
- SETUP (T_AS_CYC cycles):
  - lcd_rs = latched rs; lcd_rw = 1 for read, 0 for write; lcd_e=0;
  - write: lcd_db_oe=1, lcd_db_o = data;
  - read: lcd_db_oe=0.
- E_HIGH (T_PW_CYC cycles): lcd_e=1, other outputs unchanged. On a read, lcd_db_i is captured on the last E_HIGH cycle.
- HOLD (T_H_CYC cycles):
  - lcd_e=0, rs/rw/db unchanged;
  - read: rd_data updated and rd_valid pulses on the first HOLD cycle.
- GAP (T_GAP_CYC cycles): lcd_db_oe=0, lcd_rw=0, lcd_rs unchanged, busy still 1.
- busy returns to 0 in the cycle the FSM re-enters IDLE. A request in that same cycle is accepted.
- Timing:
  - busy is high for T_AS_CYC+T_PW_CYC+T_H_CYC+T_GAP_CYC cycles, 36 with defaults;
  - lcd_e rises T_AS_CYC cycles after busy rises.
- Any request while busy=1 is ignored, drop pulses for 1 cycle, and the transfer in progress is unaffected.
- lcd_e is never high while lcd_db_oe changes, or while lcd_rs/lcd_rw change.

Optional Feature:
- Macro: LCD1602_NIBBLE_EN.
- Defined (4-bit bus mode):
  - each request runs two sub-transfers, SETUP/E_HIGH/HOLD/GAP each: high nibble first, then low nibble;
  - data uses lcd_db_o[7:4]; lcd_db_o[3:0]=0;
  - reads capture lcd_db_i[7:4] into rd_data[7:4] on the first E, then rd_data[3:0] on the second E;
  - a single rd_valid pulse follows the second E only;
  - busy lasts 2x the 8-bit duration, 72 cycles with defaults;
  - reset between nibbles aborts both nibbles.
- Undefined: 8-bit mode as described in Behaviour; the nibble logic is absent.

Test Plan:
- Write, default params, req_wr with rs=1, data=0x41:
  - lcd_rs=1 and lcd_db_o=0x41 with oe=1 from cycle 1;
  - lcd_e high on cycles 3..14;
  - busy high for exactly 36 cycles.
- Read, default params, req_rd with rs=0, lcd_db_i=0x80:
  - lcd_rw=1 and oe=0 throughout SETUP..HOLD;
  - one-cycle rd_valid pulse; rd_data=0x80.
- Request while busy:
  - second req_wr 10 cycles after the first -> drop pulses for 1 cycle;
  - the first transfer's outputs are unchanged;
  - busy still totals 36 cycles.
- Simultaneous req_wr and req_rd in IDLE:
  - a write is performed (lcd_rw=0);
  - drop pulses; rd_valid never pulses.
- rst asserted on the 5th E_HIGH cycle:
  - next edge: lcd_e=0, busy=0, oe=0, all outputs at reset values;
  - a new req_wr after rst is released completes normally.
- With LCD1602_NIBBLE_EN defined:
  - write 0xA5 -> two E pulses with lcd_db_o[7:4]=0xA then 0x5; busy for 72 cycles;
  - read with lcd_db_i[7:4]=0x3 on the first E and 0xC on the second -> rd_data=0x3C.
